// File: rtl/dco_cal_ctrl.sv
`timescale 1ns/1ps
// ============================================================================
// dco_cal_ctrl
// ----------------------------------------------------------------------------
// Frequency-calibration sequencer for the 5-bit DCO in the ADPLL.
//
// A `start` pulse in IDLE opens the loop and runs a 5-step successive-
// approximation search, MSB first, over the DCO threshold code. Each trial
// holds the DCO in reset for two cycles and then counts DCO rising edges over
// WINDOW clk cycles. A trial bit is kept when its edge count meets `target`.
// The search finds the largest code that still meets the target. That code is
// then re-measured once, and `cal_err` is raised if it now falls short. The
// final code stays on `thresh_val` until the next calibration.
//
// Trial timing, in clk cycles:
//   search trial : SETTLE(2) + MEAS(WINDOW) + DECIDE(1)
//   verify trial : VERIFY_SETTLE(2) + VERIFY_MEAS(WINDOW + final compare)
// If `start` is sampled at edge k, `done` is high in cycle k + 6*(WINDOW+3) + 1.
//
// Parameters
//   WINDOW      measurement window length in clk cycles (2..255)
//   CNT_W       width of the edge counter and of `target`
//
// Ports
//   clk         system clock; the DCO output is a register in this domain
//   reset       synchronous, active-high reset
//   start       single-cycle calibration request, honoured only in IDLE
//   target      minimum rising-edge count per window, sampled on `start`
//   dco_clk     DCO output (same clock domain, no synchroniser)
//   thresh_val  threshold code driven to the DCO
//   dco_rst     DCO reset request (ORed with system reset at the top level)
//   loop_open   high while calibrating; the top level forces DCO ctrl to 0
//   busy        calibration in progress
//   done        one-cycle pulse when calibration completes
//   cal_err     verify count fell below target; held until the next start
//   meas_count  edge count of the most recently completed window
// ============================================================================
module dco_cal_ctrl #(
    parameter int WINDOW = 64,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] target,
    input  logic             dco_clk,
    output logic [4:0]       thresh_val,
    output logic             dco_rst,
    output logic             loop_open,
    output logic             busy,
    output logic             done,
    output logic             cal_err,
    output logic [CNT_W-1:0] meas_count
);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        MEAS,
        DECIDE,
        VERIFY_SETTLE,
        VERIFY_MEAS,
        DONE
    } state_t;

    // Last timer value of a search window. The verify window runs one cycle
    // longer: that extra cycle is the final compare, and its sample is not
    // counted.
    localparam logic [7:0]       MEAS_LAST   = 8'(WINDOW - 1);
    localparam logic [7:0]       VERIFY_LAST = 8'(WINDOW);
    localparam logic [7:0]       SETTLE_LAST = 8'd1;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [4:0]       FIRST_TRIAL = 5'd16;

    state_t           state;
    state_t           state_nxt;

    logic [4:0]       code;       // bits already decided by the search
    logic [2:0]       bit_idx;    // bit currently under trial
    logic [CNT_W-1:0] target_q;   // target captured when start is accepted
    logic [7:0]       tmr;        // cycle counter within SETTLE / MEAS phases
    logic [CNT_W-1:0] edge_cnt;   // saturating rising-edge counter
    logic             dco_prev;   // previous dco_clk sample, for edge detect

    logic [4:0]       trial_bit;
    logic             pass;
    logic [4:0]       code_upd;
    logic             rise;
    logic             cnt_sat;

    // ------------------------------------------------------------------------
    // Shared datapath terms
    // ------------------------------------------------------------------------
    assign trial_bit = 5'b00001 << bit_idx;
    assign pass      = (edge_cnt >= target_q);
    assign code_upd  = pass ? (code | trial_bit) : code;
    assign rise      = dco_clk & ~dco_prev;
    assign cnt_sat   = (edge_cnt == CNT_MAX);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples the pre-edge values and process order cannot change behaviour.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic and Moore outputs
    // ------------------------------------------------------------------------
    // NOTE: every output of this block gets a default before the case
    // statement, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        loop_open = 1'b1;
        dco_rst   = 1'b0;
        done      = 1'b0;

        case (state)
            IDLE: begin
                busy      = 1'b0;
                loop_open = 1'b0;
                if (start) begin
                    state_nxt = SETTLE;
                end
            end

            SETTLE: begin
                dco_rst = 1'b1;
                if (tmr == SETTLE_LAST) begin
                    state_nxt = MEAS;
                end
            end

            MEAS: begin
                if (tmr == MEAS_LAST) begin
                    state_nxt = DECIDE;
                end
            end

            DECIDE: begin
                state_nxt = (bit_idx == 3'd0) ? VERIFY_SETTLE : SETTLE;
            end

            VERIFY_SETTLE: begin
                dco_rst = 1'b1;
                if (tmr == SETTLE_LAST) begin
                    state_nxt = VERIFY_MEAS;
                end
            end

            VERIFY_MEAS: begin
                if (tmr == VERIFY_LAST) begin
                    state_nxt = DONE;
                end
            end

            DONE: begin
                busy      = 1'b0;
                loop_open = 1'b0;
                done      = 1'b1;
                state_nxt = IDLE;
            end

            default: begin
                busy      = 1'b0;
                loop_open = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: search registers, window timer, edge counter, results
    // ------------------------------------------------------------------------
    // NOTE: reset is synchronous, sampled inside the clocked block, and every
    // register gets its reset value. A reset mid-search discards the partial
    // code and returns `thresh_val` to the first trial code.
    always_ff @(posedge clk) begin
        if (reset) begin
            thresh_val <= FIRST_TRIAL;
            cal_err    <= 1'b0;
            meas_count <= '0;
            code       <= '0;
            bit_idx    <= 3'd4;
            target_q   <= '0;
            tmr        <= '0;
            edge_cnt   <= '0;
            dco_prev   <= 1'b0;
        end else begin
            // dco_prev normally follows the input. It is cleared on entry to
            // each settle phase and then tracks the input during the second
            // settle cycle. So a level that is already high when the window
            // opens does not count as an edge.
            dco_prev <= dco_clk;

            case (state)
                IDLE: begin
                    if (start) begin
                        target_q   <= target;
                        code       <= '0;
                        cal_err    <= 1'b0;
                        bit_idx    <= 3'd4;
                        thresh_val <= FIRST_TRIAL;
                        tmr        <= '0;
                        edge_cnt   <= '0;
                        dco_prev   <= 1'b0;
                    end
                end

                SETTLE, VERIFY_SETTLE: begin
                    edge_cnt <= '0;
                    tmr      <= (tmr == SETTLE_LAST) ? 8'd0 : tmr + 8'd1;
                end

                MEAS: begin
                    tmr <= tmr + 8'd1;
                    if (rise && !cnt_sat) begin
                        edge_cnt <= edge_cnt + 1'b1;
                    end
                end

                DECIDE: begin
                    meas_count <= edge_cnt;
                    code       <= code_upd;
                    tmr        <= '0;
                    edge_cnt   <= '0;
                    dco_prev   <= 1'b0;
                    if (bit_idx == 3'd0) begin
                        // Re-measure the code the search settled on.
                        thresh_val <= code_upd;
                    end else begin
                        bit_idx    <= bit_idx - 3'd1;
                        thresh_val <= code_upd | (trial_bit >> 1);
                    end
                end

                VERIFY_MEAS: begin
                    if (tmr == VERIFY_LAST) begin
                        meas_count <= edge_cnt;
                        cal_err    <= (edge_cnt < target_q);
                    end else begin
                        tmr <= tmr + 8'd1;
                        if (rise && !cnt_sat) begin
                            edge_cnt <= edge_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    // DONE: thresh_val keeps the final code through IDLE.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dco_cal_ctrl.sv
`timescale 1ns/1ps
// ============================================================================
// tb_dco_cal_ctrl
// ----------------------------------------------------------------------------
// Directed bench for dco_cal_ctrl.
//
// u_dut (WINDOW=64, CNT_W=8) is driven by a behavioural DCO: half-period of
// thresh_val+1 cycles, held low while in reset. The DCO output can be forced
// high instead.
// u_sat (WINDOW=255, CNT_W=7) is driven by a signal that toggles every cycle,
// so its edge counter reaches saturation.
//
// Expected edge counts in a 64-cycle window, for code t: rising edges fall in
// window cycles (t+2) + 2(t+1)m.
//   t=16 -> 2, t=8 -> 4, t=4 -> 6, t=2 -> 11, t=3 -> 8, t=31 -> 1, t=0 -> 32
// ============================================================================
module tb_dco_cal_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] target;
    logic       dco_clk;
    logic [4:0] thresh_val;
    logic       dco_rst, loop_open, busy, done, cal_err;
    logic [7:0] meas_count;

    logic       start_s;
    logic [6:0] target_s;
    logic       tgl;
    logic [4:0] thresh_s;
    logic       dco_rst_s, loop_open_s, busy_s, done_s, cal_err_s;
    logic [6:0] meas_s;

    // Behavioural DCO for u_dut.
    logic       dco_q;
    logic [4:0] dco_ph;
    logic       dco_hold;

    int total = 0;
    int bad   = 0;
    int lat;
    int dones;
    logic [4:0] trial_codes [6];

    always #5 clk = ~clk;

    assign dco_clk = dco_hold ? 1'b1 : dco_q;

    always @(posedge clk) begin
        if (reset || dco_rst) begin
            dco_ph <= '0;
            dco_q  <= 1'b0;
        end else if (dco_ph == thresh_val) begin
            dco_ph <= '0;
            dco_q  <= ~dco_q;
        end else begin
            dco_ph <= dco_ph + 5'd1;
        end
    end

    always @(posedge clk) begin
        if (reset) tgl <= 1'b0;
        else       tgl <= ~tgl;
    end

    dco_cal_ctrl #(.WINDOW(64), .CNT_W(8)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .target     (target),
        .dco_clk    (dco_clk),
        .thresh_val (thresh_val),
        .dco_rst    (dco_rst),
        .loop_open  (loop_open),
        .busy       (busy),
        .done       (done),
        .cal_err    (cal_err),
        .meas_count (meas_count)
    );

    dco_cal_ctrl #(.WINDOW(255), .CNT_W(7)) u_sat (
        .clk        (clk),
        .reset      (reset),
        .start      (start_s),
        .target     (target_s),
        .dco_clk    (tgl),
        .thresh_val (thresh_s),
        .dco_rst    (dco_rst_s),
        .loop_open  (loop_open_s),
        .busy       (busy_s),
        .done       (done_s),
        .cal_err    (cal_err_s),
        .meas_count (meas_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Start a calibration on u_dut. The task returns at the negedge of cycle
    // k+1, where k is the edge that accepted start.
    task automatic start_cal(input logic [7:0] tgt);
        @(negedge clk);
        target = tgt;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Wait for done on u_dut. The caller is in cycle k+base when this is
    // called. On return, lat = cycle offset of done (or -1 on timeout) and
    // dones = number of done-high cycles seen. Mid-window trial codes are
    // recorded along the way.
    task automatic wait_done(input int base, output int l, output int d);
        l = -1;
        d = 0;
        for (int i = base; i <= base + 600; i++) begin
            if (i >= 31 && ((i - 31) % 67) == 0 && ((i - 31) / 67) < 6)
                trial_codes[(i - 31) / 67] = thresh_val;
            if (done) begin
                d++;
                l = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b1;   // start together with reset: reset must win
        target   = 8'd8;
        start_s  = 1'b0;
        target_s = 7'd0;
        dco_hold = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b0;
        check("rst_thresh",    thresh_val, 16);
        check("rst_busy",      busy,       0);
        check("rst_dco_rst",   dco_rst,    0);
        check("rst_loop_open", loop_open,  0);
        check("rst_done",      done,       0);
        check("rst_cal_err",   cal_err,    0);
        check("rst_meas",      meas_count, 0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_start_ignored", busy, 0);

        // ---- Main search, target 8 -> code 3 ----
        start_cal(8'd8);
        check("k1_busy",      busy,       1);
        check("k1_loop_open", loop_open,  1);
        check("k1_dco_rst",   dco_rst,    1);
        check("k1_thresh",    thresh_val, 16);
        wait_done(1, lat, dones);
        check("t8_latency", lat, 403);
        check("t8_code0", trial_codes[0], 16);
        check("t8_code1", trial_codes[1], 8);
        check("t8_code2", trial_codes[2], 4);
        check("t8_code3", trial_codes[3], 2);
        check("t8_code4", trial_codes[4], 3);
        check("t8_verify_code", trial_codes[5], 3);
        check("t8_done_busy", busy, 0);
        @(negedge clk);
        check("t8_done_pulse", done,       0);
        check("t8_thresh",     thresh_val, 3);
        check("t8_cal_err",    cal_err,    0);
        check("t8_meas",       meas_count, 8);

        // ---- target 0: every trial passes ----
        start_cal(8'd0);
        wait_done(1, lat, dones);
        check("t0_latency", lat, 403);
        @(negedge clk);
        check("t0_thresh",  thresh_val, 31);
        check("t0_cal_err", cal_err,    0);
        check("t0_meas",    meas_count, 1);

        // ---- target 255: every trial fails ----
        start_cal(8'd255);
        wait_done(1, lat, dones);
        @(negedge clk);
        check("t255_thresh",  thresh_val, 0);
        check("t255_cal_err", cal_err,    1);
        check("t255_meas",    meas_count, 32);

        // ---- reset during the third MEAS window ----
        start_cal(8'd8);
        repeat (149) @(negedge clk);            // now in cycle k+150
        check("mid_trial3_code", thresh_val, 4);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_busy",    busy,       0);
        check("mid_rst_thresh",  thresh_val, 16);
        check("mid_rst_dco_rst", dco_rst,    0);
        check("mid_rst_loop",    loop_open,  0);
        check("mid_rst_meas",    meas_count, 0);
        check("mid_rst_cal_err", cal_err,    0);
        start_cal(8'd8);
        wait_done(1, lat, dones);
        check("rerun_latency", lat, 403);
        @(negedge clk);
        check("rerun_thresh", thresh_val, 3);

        // ---- start while busy and during done: both ignored ----
        start_cal(8'd8);
        repeat (99) @(negedge clk);             // cycle k+100
        start  = 1'b1;
        target = 8'd0;
        @(negedge clk);
        start  = 1'b0;
        target = 8'd8;
        wait_done(101, lat, dones);
        check("ign_latency", lat, 403);
        start  = 1'b1;                          // in the done cycle
        target = 8'd0;
        @(negedge clk);
        start  = 1'b0;
        target = 8'd8;
        check("ign_done_start_busy", busy,       0);
        check("ign_thresh",          thresh_val, 3);
        check("ign_done_count",      dones + 32'(done), 1);
        start = 1'b1;                           // IDLE cycle after done
        @(negedge clk);
        start = 1'b0;
        check("idle_start_busy", busy, 1);
        wait_done(1, lat, dones);
        check("idle_start_latency", lat, 403);
        @(negedge clk);

        // ---- dco_clk held high: no edges ----
        dco_hold = 1'b1;
        start_cal(8'd1);
        wait_done(1, lat, dones);
        @(negedge clk);
        dco_hold = 1'b0;
        check("hold_meas",    meas_count, 0);
        check("hold_thresh",  thresh_val, 0);
        check("hold_cal_err", cal_err,    1);

        // ---- saturation: WINDOW=255, CNT_W=7, toggling input ----
        @(negedge clk);
        target_s = 7'd127;
        start_s  = 1'b1;
        @(negedge clk);
        start_s  = 1'b0;
        lat = -1;
        for (int i = 1; i <= 2000; i++) begin
            if (done_s) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
        check("sat_latency", lat, 1549);
        @(negedge clk);
        check("sat_meas",    meas_s,    127);
        check("sat_thresh",  thresh_s,  31);
        check("sat_cal_err", cal_err_s, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
